// File: rtl/riscv_types_pkg.sv
// rtl/riscv_types_pkg.sv - shared M-extension divide opcodes, controller FSM states and timing constants
package riscv_types_pkg;

  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  localparam int DEFAULT_DIV_LATENCY = 4;
  localparam int DIV_WD_MARGIN       = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } div_ctrl_state_e;

endpackage

// File: rtl/div_special_case.sv
// rtl/div_special_case.sv - resolves divide-by-zero, signed overflow and illegal ops locally
module div_special_case
  import riscv_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic                  o_is_special,
  output logic [DATA_WIDTH-1:0] o_special_result
);

  localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic w_is_rem;
  logic w_is_signed;
  logic w_is_legal;

  assign w_is_rem    = (i_op == OP_REM) || (i_op == OP_REMU);
  assign w_is_signed = (i_op == OP_DIV) || (i_op == OP_REM);
  assign w_is_legal  = w_is_rem || w_is_signed || (i_op == OP_DIVU);

  always_comb begin
    o_is_special     = 1'b0;
    o_special_result = '0;
    if (!w_is_legal) begin
      o_is_special     = 1'b1;
      o_special_result = '0;
    end else if (i_b == '0) begin
      o_is_special     = 1'b1;
      o_special_result = w_is_rem ? i_a : '1;
    end else if (w_is_signed && (i_a == MOST_NEG) && (i_b == '1)) begin
      o_is_special     = 1'b1;
      o_special_result = w_is_rem ? '0 : i_a;
    end
  end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - div_unit issue/retire controller with flush and watchdog; optional DIV_RESULT_CACHE_EN result cache
module div_issue_ctrl
  import riscv_types_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = DEFAULT_DIV_LATENCY,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_a_i,
  input  logic [DATA_WIDTH-1:0] req_b_i,
  input  logic [TAG_WIDTH-1:0]  req_rd_i,
  input  logic                  flush_i,
  output logic                  div_start_o,
  output logic [2:0]            div_op_o,
  output logic [DATA_WIDTH-1:0] div_a_o,
  output logic [DATA_WIDTH-1:0] div_b_o,
  input  logic                  div_done_i,
  input  logic [DATA_WIDTH-1:0] div_result_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_result_o,
  output logic [TAG_WIDTH-1:0]  rsp_rd_o,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int WD_LIMIT = LATENCY + DIV_WD_MARGIN;
  localparam int WD_W     = $clog2(WD_LIMIT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_LIMIT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  div_ctrl_state_e         r_state;
  logic [2:0]              r_op;
  logic [DATA_WIDTH-1:0]   r_a;
  logic [DATA_WIDTH-1:0]   r_b;
  logic [TAG_WIDTH-1:0]    r_rd;
  logic [DATA_WIDTH-1:0]   r_result;
  logic                    r_start;
  logic                    r_err;
  logic [WD_W-1:0]         r_wd;

  logic                    w_accept;
  logic                    w_is_special;
  logic [DATA_WIDTH-1:0]   w_special_result;
  logic                    w_wd_expired;
  logic                    w_hit;
  logic [DATA_WIDTH-1:0]   w_cache_result;

  div_special_case #(.DATA_WIDTH(DATA_WIDTH)) u_special (
    .i_op             (req_op_i),
    .i_a              (req_a_i),
    .i_b              (req_b_i),
    .o_is_special     (w_is_special),
    .o_special_result (w_special_result)
  );

  assign w_accept     = (r_state == S_IDLE) && req_valid_i && !flush_i;
  assign w_wd_expired = (r_wd >= WD_LAST);

`ifdef DIV_RESULT_CACHE_EN
  logic                  r_c_valid;
  logic [2:0]            r_c_op;
  logic [DATA_WIDTH-1:0] r_c_a;
  logic [DATA_WIDTH-1:0] r_c_b;
  logic [DATA_WIDTH-1:0] r_c_result;

  assign w_hit          = r_c_valid && (r_c_op == req_op_i) && (r_c_a == req_a_i) && (r_c_b == req_b_i);
  assign w_cache_result = r_c_result;

  // Only a clean normal-path completion refreshes the entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_c_valid  <= 1'b0;
      r_c_op     <= '0;
      r_c_a      <= '0;
      r_c_b      <= '0;
      r_c_result <= '0;
    end else if ((r_state == S_WAIT) && div_done_i && !flush_i) begin
      r_c_valid  <= 1'b1;
      r_c_op     <= r_op;
      r_c_a      <= r_a;
      r_c_b      <= r_b;
      r_c_result <= div_result_i;
    end
  end
`else
  assign w_hit          = 1'b0;
  assign w_cache_result = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_rd     <= '0;
      r_result <= '0;
      r_start  <= 1'b0;
      r_err    <= 1'b0;
      r_wd     <= '0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op <= req_op_i;
            r_a  <= req_a_i;
            r_b  <= req_b_i;
            r_rd <= req_rd_i;
            r_wd <= '0;
            if (w_is_special) begin
              r_result <= w_special_result;
              r_state  <= S_RESP;
            end else if (w_hit) begin
              r_result <= w_cache_result;
              r_state  <= S_RESP;
            end else begin
              r_start <= 1'b1;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (div_done_i) begin
            if (flush_i) begin
              r_state <= S_IDLE;
            end else begin
              r_result <= div_result_i;
              r_state  <= S_RESP;
            end
          end else if (flush_i) begin
            r_wd    <= r_wd + WD_ONE;
            r_state <= S_DRAIN;
          end else if (w_wd_expired) begin
            r_result <= '1;
            r_err    <= 1'b1;
            r_state  <= S_RESP;
          end else begin
            r_wd <= r_wd + WD_ONE;
          end
        end
        S_DRAIN: begin
          // A lost done must not wedge the controller after a flush.
          if (div_done_i) begin
            r_state <= S_IDLE;
          end else if (w_wd_expired) begin
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_wd <= r_wd + WD_ONE;
          end
        end
        S_RESP: begin
          if (flush_i || rsp_ready_i) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (r_state == S_IDLE) && !flush_i;
  assign div_start_o  = r_start;
  assign div_op_o     = r_op;
  assign div_a_o      = r_a;
  assign div_b_o      = r_b;
  assign rsp_valid_o  = (r_state == S_RESP);
  assign rsp_result_o = r_result;
  assign rsp_rd_o     = r_rd;
  assign busy_o       = (r_state != S_IDLE);
  assign err_o        = r_err;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed scoreboard bench for div_issue_ctrl with a behavioural div_unit stub
module tb_div_issue_ctrl;

  localparam int LAT = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        div_start_o;
  logic [2:0]  div_op_o;
  logic [31:0] div_a_o;
  logic [31:0] div_b_o;
  logic        div_done_i;
  logic [31:0] div_result_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_result_o;
  logic [4:0]  rsp_rd_o;
  logic        busy_o;
  logic        err_o;

  div_issue_ctrl #(.DATA_WIDTH(32), .LATENCY(LAT), .TAG_WIDTH(5)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_a_i      (req_a_i),
    .req_b_i      (req_b_i),
    .req_rd_i     (req_rd_i),
    .flush_i      (flush_i),
    .div_start_o  (div_start_o),
    .div_op_o     (div_op_o),
    .div_a_o      (div_a_o),
    .div_b_o      (div_b_o),
    .div_done_i   (div_done_i),
    .div_result_i (div_result_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_rd_o     (rsp_rd_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_start = 0;

  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'b100:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'b101:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110:  return (b == 0) ? a : ovf ? 32'h0 : 32'($signed(a) % $signed(b));
      3'b111:  return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural div_unit: done arrives LAT cycles after it samples start.
  logic        stub_en;
  logic        stub_active;
  int          stub_cnt;
  logic [31:0] stub_res;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stub_active <= 1'b0;
      stub_cnt    <= 0;
      stub_res    <= 32'h0;
    end else if (div_start_o) begin
      stub_active <= 1'b1;
      stub_cnt    <= LAT;
      stub_res    <= ref_div(div_op_o, div_a_o, div_b_o);
    end else if (stub_active) begin
      if (stub_cnt == 0) stub_active <= 1'b0;
      else stub_cnt <= stub_cnt - 1;
    end
  end

  always @(posedge clk_i) begin
    if (div_start_o) n_start <= n_start + 1;
  end

  assign div_done_i   = stub_en && stub_active && (stub_cnt == 0);
  assign div_result_i = stub_res;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_req(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_res, input int exp_lat, input int exp_starts);
    exp_t e;
    int   lat;
    int   starts0;
    logic s0;
    e.res = exp_res;
    e.rd  = rd;
    sb.push_back(e);
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_rd_i    = rd;
    chk({tag, "_ready"}, 32'(req_ready_o), 32'd1);
    starts0 = n_start;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    lat = -1;
    s0  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (k == 0) s0 = div_start_o;
      if (rsp_valid_o) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_start"}, 32'(n_start - starts0), 32'(exp_starts));
    if (exp_starts != 0) chk({tag, "_start_e0"}, 32'(s0), 32'd1);
    e = sb.pop_front();
    chk({tag, "_res"}, rsp_result_o, e.res);
    chk({tag, "_rd"}, 32'(rsp_rd_o), 32'(e.rd));
    if (rsp_ready_i) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  initial begin
    int done_k;
    int ready_k;
    logic rsp_seen;

    rst_ni      = 1'b0;
    req_valid_i = 1'b0;
    req_op_i    = 3'b0;
    req_a_i     = 32'h0;
    req_b_i     = 32'h0;
    req_rd_i    = 5'h0;
    flush_i     = 1'b0;
    rsp_ready_i = 1'b1;
    stub_en     = 1'b1;
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    chk("rst_ready", 32'(req_ready_o), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("rst_start", 32'(div_start_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_result", rsp_result_o, 32'd0);

    run_req("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd3, ref_div(3'b101, 32'd100, 32'd7), LAT + 2, 1);
    chk("divu_res_const", rsp_result_o, 32'd14);
    run_req("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 32'h8000_0000, 0, 0);
    run_req("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5, 32'h0, 0, 0);
    run_req("remu_b0", 3'b111, 32'h1234, 32'h0, 5'd6, 32'h1234, 0, 0);
    run_req("div_b0", 3'b100, 32'd7, 32'h0, 5'd7, 32'hFFFF_FFFF, 0, 0);
    run_req("illegal_op", 3'b010, 32'd9, 32'd3, 5'd8, 32'h0, 0, 0);
    run_req("div_neg", 3'b100, -32'sd50, 32'd7, 5'd10, ref_div(3'b100, -32'sd50, 32'd7), LAT + 2, 1);
    run_req("rem_neg", 3'b110, -32'sd50, 32'd7, 5'd11, ref_div(3'b110, -32'sd50, 32'd7), LAT + 2, 1);

    run_req("div_50_5_a", 3'b100, 32'd50, 32'd5, 5'd12, 32'd10, LAT + 2, 1);
`ifdef DIV_RESULT_CACHE_EN
    run_req("div_50_5_hit", 3'b100, 32'd50, 32'd5, 5'd13, 32'd10, 0, 0);
`else
    run_req("div_50_5_b", 3'b100, 32'd50, 32'd5, 5'd13, 32'd10, LAT + 2, 1);
`endif

    // Writeback stalls: response must hold steady.
    rsp_ready_i = 1'b0;
    run_req("hold", 3'b111, 32'd1000, 32'd33, 5'd17, 32'd10, LAT + 2, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hold_valid", 32'(rsp_valid_o), 32'd1);
      chk("hold_res", rsp_result_o, 32'd10);
      chk("hold_rd", 32'(rsp_rd_o), 32'd17);
    end
    rsp_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    chk("hold_release", 32'(rsp_valid_o), 32'd0);

    // Flush two cycles after start: done drained, nothing delivered.
    req_valid_i = 1'b1;
    req_op_i    = 3'b101;
    req_a_i     = 32'd99;
    req_b_i     = 32'd3;
    req_rd_i    = 5'd20;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);
    @(negedge clk_i);
    chk("flush_ready_wait", 32'(req_ready_o), 32'd0);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    done_k   = -1;
    ready_k  = -1;
    rsp_seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (k == 0) chk("flush_busy", 32'(busy_o), 32'd1);
      if (rsp_valid_o) rsp_seen = 1'b1;
      if (div_done_i && done_k < 0) done_k = k;
      if (req_ready_o) begin
        ready_k = k;
        break;
      end
    end
    chk("flush_done_k", 32'(done_k), 32'd2);
    chk("flush_ready_k", 32'(ready_k), 32'd3);
    chk("flush_no_rsp", 32'(rsp_seen), 32'd0);

    // Flush in RESP drops the response.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    req_op_i    = 3'b100;
    req_a_i     = 32'd1;
    req_b_i     = 32'd0;
    req_rd_i    = 5'd2;
    @(posedge clk_i);
    #1 req_valid_i = 1'b0;
    @(negedge clk_i);
    chk("rflush_valid", 32'(rsp_valid_o), 32'd1);
    flush_i = 1'b1;
    @(posedge clk_i);
    #1 flush_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    chk("rflush_dropped", 32'(rsp_valid_o), 32'd0);
    chk("rflush_ready", 32'(req_ready_o), 32'd1);

    // Watchdog: div_unit never answers.
    stub_en = 1'b0;
    run_req("wd", 3'b101, 32'd5, 32'd1, 5'd21, 32'hFFFF_FFFF, LAT + 4, 1);
    chk("wd_err", 32'(err_o), 32'd1);
    repeat (LAT + 2) @(negedge clk_i);
    stub_en = 1'b1;
    run_req("after_wd", 3'b101, 32'd8, 32'd2, 5'd22, 32'd4, LAT + 2, 1);
    chk("wd_err_sticky", 32'(err_o), 32'd1);

    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("reset_err", 32'(err_o), 32'd0);
    chk("reset_ready", 32'(req_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
